// File: rtl/vdcm_pkg.sv
`default_nettype none
// ============================================================================
// Module : vdcm_pkg
// Brief  : Shared types and sizes for the substream fetch scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package vdcm_pkg;

   localparam int NUM_SSM    = 4;
   localparam int MUX_WORD_W = 128;
   localparam int PUSH_CNT_W = $clog2(NUM_SSM + 1);

   typedef logic [1:0] ssm_id_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } fsm_t;

   function automatic logic [PUSH_CNT_W-1:0] count_ones(input logic [NUM_SSM-1:0] v);
      logic [PUSH_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_SSM; i++) begin
         n = n + PUSH_CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ssm_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : ssm_word_fifo
// Brief  : Per-substream word FIFO; one write, one pop, sync flush, head output.
// Rev    : 1.0  initial release
// ============================================================================
module ssm_word_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 128
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] head,
   output logic         vld
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;

   logic w_pop;
   logic w_full;
   logic w_push;

   assign w_pop  = rd_en && (r_cnt != '0);
   assign w_full = (r_cnt == CW'(DEPTH));
   assign w_push = wr_en && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
   end

   assign vld  = (r_cnt != '0);
   assign head = vld ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: rtl/ssm_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module : ssm_fetch_sched
// Brief  : Shares one bitstream RAM read port among four substream parsers.
// Rev    : 1.0  initial release
// ============================================================================
module ssm_fetch_sched
   import vdcm_pkg::*;
#(
   parameter int AW      = 8,
   parameter int DEPTH   = 4,
   parameter int PREFILL = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start_dec,
   output logic                          mem_rd_en,
   output logic [AW-1:0]                 mem_addr,
   input  logic [MUX_WORD_W-1:0]         mem_rdata,
   input  logic [NUM_SSM-1:0]            ssm_rd_en,
   output logic [NUM_SSM*MUX_WORD_W-1:0] ssm_data,
   output logic [NUM_SSM-1:0]            ssm_vld,
   output logic                          prefill_done,
   output logic [NUM_SSM-1:0]            underflow_err
);

   localparam int c_q_depth = NUM_SSM * DEPTH;
   localparam int QW        = $clog2(c_q_depth);
   localparam int QCW       = QW + 1;
   localparam int c_npf     = NUM_SSM * PREFILL;
   localparam int PFW       = $clog2(c_npf);
   localparam logic [PFW-1:0] c_pf_last = PFW'(c_npf - 1);

   fsm_t                  r_state;
   fsm_t                  w_state_nxt;
   logic [PFW-1:0]        r_pf_cnt;
   logic [AW-1:0]         r_addr;
   logic                  r_inf_vld;
   logic                  r_inf_last;
   ssm_id_t               r_inf_tag;
   ssm_id_t               r_q [c_q_depth];
   logic [QW-1:0]         r_q_wptr;
   logic [QW-1:0]         r_q_rptr;
   logic [QCW-1:0]        r_q_cnt;
   logic [NUM_SSM-1:0]    r_uf;
   logic                  r_pd;

   logic [NUM_SSM-1:0]    w_vld;
   logic [NUM_SSM-1:0]    w_pop_ok;
   logic [NUM_SSM-1:0]    w_uf;
   logic [PUSH_CNT_W-1:0] w_npush;
   logic [QW-1:0]         w_push_idx [NUM_SSM];
   logic [QW-1:0]         w_idx_run;
   logic                  w_rd;
   logic                  w_rd_last;
   logic                  w_q_pop;
   ssm_id_t               w_rd_tag;

   // ---------------------------------------------------------------- FIFOs
   generate
      for (genvar k = 0; k < NUM_SSM; k++) begin : g_ssm
         logic w_wr_en;
         assign w_wr_en = r_inf_vld && (r_inf_tag == ssm_id_t'(k));

         ssm_word_fifo #(
            .DEPTH (DEPTH),
            .W     (MUX_WORD_W)
         ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .flush   (start_dec),
            .wr_en   (w_wr_en),
            .wr_data (mem_rdata),
            .rd_en   (ssm_rd_en[k]),
            .head    (ssm_data[MUX_WORD_W*k +: MUX_WORD_W]),
            .vld     (w_vld[k])
         );
      end
   endgenerate

   assign w_pop_ok = ssm_rd_en & w_vld;
   assign w_uf     = ssm_rd_en & ~w_vld;
   assign w_npush  = count_ones(w_pop_ok);

   // Simultaneous pops land in consecutive queue slots, lowest id first.
   always_comb begin
      w_idx_run = r_q_wptr;
      for (int k = 0; k < NUM_SSM; k++) begin
         w_push_idx[k] = w_idx_run;
         if (w_pop_ok[k]) w_idx_run = w_idx_run + 1'b1;
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start_dec) begin
         w_state_nxt = ST_PREFILL;
      end else begin
         case (r_state)
            ST_PREFILL: if (r_pf_cnt == c_pf_last) w_state_nxt = ST_RUN;
            ST_RUN:     w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rd      = 1'b0;
      w_rd_tag  = '0;
      w_rd_last = 1'b0;
      w_q_pop   = 1'b0;
      case (r_state)
         ST_PREFILL: begin
            w_rd      = 1'b1;
            w_rd_tag  = ssm_id_t'(r_pf_cnt);
            w_rd_last = (r_pf_cnt == c_pf_last);
         end
         ST_RUN: begin
            if (r_q_cnt != '0) begin
               w_rd     = 1'b1;
               w_q_pop  = 1'b1;
               w_rd_tag = r_q[r_q_rptr];
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pf_cnt   <= '0;
         r_addr     <= '0;
         r_inf_vld  <= 1'b0;
         r_inf_last <= 1'b0;
         r_inf_tag  <= '0;
         r_q_wptr   <= '0;
         r_q_rptr   <= '0;
         r_q_cnt    <= '0;
         r_uf       <= '0;
         r_pd       <= 1'b0;
      end else if (start_dec) begin
         r_pf_cnt   <= '0;
         r_addr     <= '0;
         r_inf_vld  <= 1'b0;
         r_inf_last <= 1'b0;
         r_inf_tag  <= '0;
         r_q_wptr   <= '0;
         r_q_rptr   <= '0;
         r_q_cnt    <= '0;
         r_uf       <= '0;
         r_pd       <= 1'b0;
      end else begin
         r_inf_vld  <= w_rd;
         r_inf_last <= w_rd_last;
         r_inf_tag  <= w_rd_tag;
         if (w_rd) r_addr <= r_addr + 1'b1;
         if (r_state == ST_PREFILL) r_pf_cnt <= r_pf_cnt + 1'b1;
         r_q_wptr <= r_q_wptr + QW'(w_npush);
         r_q_rptr <= r_q_rptr + QW'(w_q_pop);
         r_q_cnt  <= r_q_cnt + QCW'(w_npush) - QCW'(w_q_pop);
         r_uf     <= r_uf | w_uf;
         // The last prefill word lands this edge, so it is visible next cycle.
         if (r_inf_vld && r_inf_last) r_pd <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_SSM; k++) begin
         if (w_pop_ok[k] && !start_dec) r_q[w_push_idx[k]] <= ssm_id_t'(k);
      end
   end

   assign mem_rd_en     = w_rd;
   assign mem_addr      = r_addr;
   assign ssm_vld       = w_vld;
   assign prefill_done  = r_pd;
   assign underflow_err = r_uf;

endmodule
`default_nettype wire
